// File: rtl/hdmi_data_island_receiver_if.sv
// Bus bundle for hdmi_data_island_receiver.
// Inputs: three aligned 10-bit TMDS channels.
// Outputs: the reassembled packet (header, parity, four subpackets, parity-check
// flags), a packet strobe, an island-status flag, a malformed-island pulse, and
// hsync/vsync recovered from channel 0.
// The master modport is the symbol source and packet consumer. The slave modport
// is the receiver.
interface hdmi_data_island_receiver_if;
  logic [9:0]  tmds0;
  logic [9:0]  tmds1;
  logic [9:0]  tmds2;
  logic        packet_valid;
  logic [23:0] header;
  logic [7:0]  header_ecc;
  logic [63:0] sub0;
  logic [63:0] sub1;
  logic [63:0] sub2;
  logic [63:0] sub3;
  logic [4:0]  ecc_error;
  logic        sym_error;
  logic        in_island;
  logic        hsync;
  logic        vsync;

  modport master (
    output tmds0, tmds1, tmds2,
    input  packet_valid, header, header_ecc, sub0, sub1, sub2, sub3,
           ecc_error, sym_error, in_island, hsync, vsync
  );

  modport slave (
    input  tmds0, tmds1, tmds2,
    output packet_valid, header, header_ecc, sub0, sub1, sub2, sub3,
           ecc_error, sym_error, in_island, hsync, vsync
  );
endinterface

// File: rtl/hdmi_data_island_receiver.sv
// HDMI data-island receiver.
// The block detects the guard bands on all three TMDS channels and TERC4-decodes
// the island body. It rebuilds each 32-cycle packet into a header and four
// subpackets and checks every BCH parity byte. No error correction is done.
// Ports:
//   clk_pixel  - pixel clock, the only clock
//   reset_n    - asynchronous reset, active low
//   bus        - slave side of hdmi_data_island_receiver_if (symbols in, packet out)
//
// state    | meaning
// S_IDLE   | outside an island, looking for the first lead guard band
// S_LEAD1  | one lead guard band seen, expecting the second
// S_PACKET | inside the island body, k counts the packet cycle
// S_TRAIL1 | one trail guard band seen, expecting the second
module hdmi_data_island_receiver #(
  parameter int MAX_PACKETS = 18
) (
  input  logic                         clk_pixel,
  input  logic                         reset_n,
  hdmi_data_island_receiver_if.slave   bus
);
  localparam logic [9:0] GB_CODE = 10'b0100110011;
  localparam int PW = $clog2(MAX_PACKETS + 1);
  localparam logic [PW-1:0] MAX_P = PW'(MAX_PACKETS);

  typedef enum logic [1:0] {S_IDLE, S_LEAD1, S_PACKET, S_TRAIL1} state_t;

  // Returns {valid, data}.
  function automatic logic [4:0] terc4_decode(input logic [9:0] sym);
    case (sym)
      10'b1010011100: return 5'h10;
      10'b1001100011: return 5'h11;
      10'b1011100100: return 5'h12;
      10'b1011100010: return 5'h13;
      10'b0101110001: return 5'h14;
      10'b0100011110: return 5'h15;
      10'b0110001110: return 5'h16;
      10'b0100111100: return 5'h17;
      10'b1011001100: return 5'h18;
      10'b0100111001: return 5'h19;
      10'b0110011100: return 5'h1a;
      10'b1011000110: return 5'h1b;
      10'b1010001110: return 5'h1c;
      10'b1001110001: return 5'h1d;
      10'b0101100011: return 5'h1e;
      10'b1011000011: return 5'h1f;
      default:        return 5'h00;
    endcase
  endfunction

  function automatic logic [7:0] ecc_step(input logic [7:0] e, input logic b);
    logic f;
    f = b ^ e[0];
    return {1'b0, e[7:1]} ^ (f ? 8'h83 : 8'h00);
  endfunction

  state_t          state, state_nxt;
  logic [4:0]      k, k_nxt;
  logic [PW-1:0]   pcount, pcount_nxt;
  logic [31:0]     hdr_acc, hdr_nxt;
  logic [3:0][63:0] sub_acc, sub_nxt;
  logic [7:0]      hecc, hecc_nxt;
  logic [3:0][7:0] secc, secc_nxt;
  logic [4:0]      dec0, dec1, dec2, ecc_nxt;
  logic            all_valid, is_gb, accept, complete, err;

  logic            pv_q, se_q, isl_q, hs_q, vs_q;
  logic [23:0]     hdr_q;
  logic [7:0]      hecc_q;
  logic [3:0][63:0] sub_q;
  logic [4:0]      ecc_q;

  assign dec0      = terc4_decode(bus.tmds0);
  assign dec1      = terc4_decode(bus.tmds1);
  assign dec2      = terc4_decode(bus.tmds2);
  assign all_valid = dec0[4] & dec1[4] & dec2[4];
  // Channel-0 guard band is one of the TERC4 codes for 4'b11xx.
  assign is_gb     = (bus.tmds1 == GB_CODE) && (bus.tmds2 == GB_CODE) &&
                     dec0[4] && (dec0[3:2] == 2'b11);

  always_comb begin
    state_nxt  = state;
    k_nxt      = k;
    pcount_nxt = pcount;
    accept     = 1'b0;
    complete   = 1'b0;
    err        = 1'b0;
    case (state)
      S_IDLE:  if (is_gb) state_nxt = S_LEAD1;
      S_LEAD1: begin
        if (is_gb) begin
          state_nxt  = S_PACKET;
          k_nxt      = 5'd0;
          pcount_nxt = '0;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_PACKET: begin
        if (is_gb) begin
          if (k == 5'd0 && pcount != '0) begin
            state_nxt = S_TRAIL1;
          end else begin
            err       = 1'b1;
            state_nxt = S_IDLE;
          end
        end else if (!all_valid || (k == 5'd0 && pcount >= MAX_P)) begin
          err       = 1'b1;
          state_nxt = S_IDLE;
        end else begin
          accept = 1'b1;
          k_nxt  = k + 5'd1;
          if (k == 5'd31) begin
            complete   = 1'b1;
            pcount_nxt = pcount + 1'b1;
          end
        end
      end
      S_TRAIL1: begin
        state_nxt = S_IDLE;
        if (!is_gb) err = 1'b1;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Data path. The parity registers restart from zero at k=0. They freeze once
  // the data bits are consumed, so at k=31 they hold the final computed parity.
  always_comb begin
    hdr_nxt    = hdr_acc;
    hdr_nxt[k] = dec0[2];
    hecc_nxt   = (k < 5'd24) ? ecc_step((k == 5'd0) ? 8'h00 : hecc, dec0[2]) : hecc;
    sub_nxt    = sub_acc;
    secc_nxt   = secc;
    for (int i = 0; i < 4; i++) begin
      sub_nxt[i][{k, 1'b0}] = dec1[i];
      sub_nxt[i][{k, 1'b1}] = dec2[i];
      if (k < 5'd28)
        secc_nxt[i] = ecc_step(ecc_step((k == 5'd0) ? 8'h00 : secc[i], dec1[i]), dec2[i]);
    end
    ecc_nxt[4] = (hdr_nxt[31:24] != hecc);
    for (int i = 0; i < 4; i++) ecc_nxt[i] = (sub_nxt[i][63:56] != secc[i]);
  end

  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      k       <= '0;
      pcount  <= '0;
      hdr_acc <= '0;
      sub_acc <= '0;
      hecc    <= '0;
      secc    <= '0;
      pv_q    <= 1'b0;
      se_q    <= 1'b0;
      isl_q   <= 1'b0;
      hs_q    <= 1'b0;
      vs_q    <= 1'b0;
      hdr_q   <= '0;
      hecc_q  <= '0;
      sub_q   <= '0;
      ecc_q   <= '0;
    end else begin
      state  <= state_nxt;
      k      <= k_nxt;
      pcount <= pcount_nxt;
      if (accept) begin
        hdr_acc <= hdr_nxt;
        sub_acc <= sub_nxt;
        hecc    <= hecc_nxt;
        secc    <= secc_nxt;
      end
      pv_q <= complete;
      se_q <= err;
      // Stays high for the cycle after the final trail guard band or an abort.
      isl_q <= (state != S_IDLE) || is_gb;
      if (dec0[4] && ((state != S_IDLE) || is_gb)) begin
        hs_q <= dec0[0];
        vs_q <= dec0[1];
      end
      if (complete) begin
        hdr_q  <= hdr_nxt[23:0];
        hecc_q <= hdr_nxt[31:24];
        sub_q  <= sub_nxt;
        ecc_q  <= ecc_nxt;
      end
    end
  end

  assign bus.packet_valid = pv_q;
  assign bus.header       = hdr_q;
  assign bus.header_ecc   = hecc_q;
  assign bus.sub0         = sub_q[0];
  assign bus.sub1         = sub_q[1];
  assign bus.sub2         = sub_q[2];
  assign bus.sub3         = sub_q[3];
  assign bus.ecc_error    = ecc_q;
  assign bus.sym_error    = se_q;
  assign bus.in_island    = isl_q;
  assign bus.hsync        = hs_q;
  assign bus.vsync        = vs_q;
endmodule

// File: tb/tb_hdmi_data_island_receiver.sv
module tb_hdmi_data_island_receiver;
  logic clk_pixel = 1'b0;
  logic reset_n   = 1'b0;

  hdmi_data_island_receiver_if bus();

  hdmi_data_island_receiver #(.MAX_PACKETS(18)) dut (
    .clk_pixel (clk_pixel),
    .reset_n   (reset_n),
    .bus       (bus)
  );

  always #5 clk_pixel = ~clk_pixel;

  localparam logic [9:0] GB        = 10'b0100110011;
  localparam logic [9:0] IDLE_SYM  = 10'b1101010100;
  localparam logic [9:0] VIDEO_SYM = 10'b0111110000;

  logic [9:0] terc4 [16] = '{
    10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
    10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
    10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
    10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011};

  typedef struct {
    logic [23:0]      h;
    logic [7:0]       hp;
    logic [3:0][55:0] d;
    logic [3:0][7:0]  p;
    logic             hs, vs, b3;
  } pkt_t;

  typedef struct {
    logic [9:0] s0, s1, s2;
    bit pv, se, isl;
  } step_t;

  step_t sq[$];
  pkt_t  eq[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // BCH parity as a plain serial computation over the data bits, LSB first.
  function automatic logic [7:0] ecc_of(input logic [63:0] v, input int n);
    logic [7:0] e;
    logic f;
    e = 8'h00;
    for (int b = 0; b < n; b++) begin
      f = v[b] ^ e[0];
      e = {1'b0, e[7:1]} ^ (f ? 8'h83 : 8'h00);
    end
    return e;
  endfunction

  function automatic pkt_t fix_parity(input pkt_t p);
    pkt_t q;
    q = p;
    q.hp = ecc_of({40'h0, p.h}, 24);
    for (int i = 0; i < 4; i++) q.p[i] = ecc_of({8'h0, p.d[i]}, 56);
    return q;
  endfunction

  function automatic pkt_t rand_pkt();
    pkt_t p;
    int w, pos;
    p.h  = 24'($urandom);
    p.hs = 1'($urandom);
    p.vs = 1'($urandom);
    p.b3 = 1'($urandom);
    for (int i = 0; i < 4; i++) p.d[i] = 56'({$urandom, $urandom});
    p = fix_parity(p);
    if ($urandom_range(0, 2) == 0) begin
      w   = $urandom_range(0, 4);
      pos = $urandom_range(0, 7);
      if (w == 4) p.hp[pos] = ~p.hp[pos];
      else        p.p[w][pos] = ~p.p[w][pos];
    end
    return p;
  endfunction

  task automatic add(input logic [9:0] s0, input logic [9:0] s1, input logic [9:0] s2,
                     input bit pv, input bit se, input bit isl);
    step_t s;
    s.s0 = s0; s.s1 = s1; s.s2 = s2; s.pv = pv; s.se = se; s.isl = isl;
    sq.push_back(s);
  endtask

  task automatic add_gb(input logic [1:0] low, input bit se, input bit isl);
    add(terc4[{2'b11, low}], GB, GB, 1'b0, se, isl);
  endtask

  task automatic sym_of(input pkt_t p, input int k,
                        output logic [9:0] s0, output logic [9:0] s1, output logic [9:0] s2);
    logic [31:0] hb;
    logic [63:0] full;
    logic [3:0]  d0, d1, d2;
    hb = {p.hp, p.h};
    d0 = {p.b3, hb[k], p.vs, p.hs};
    for (int i = 0; i < 4; i++) begin
      full  = {p.p[i], p.d[i]};
      d1[i] = full[2*k];
      d2[i] = full[2*k+1];
    end
    s0 = terc4[d0];
    s1 = terc4[d1];
    s2 = terc4[d2];
  endtask

  task automatic push_pkt(input pkt_t p, input int k0, input int k1, input bit done, input bit isl);
    logic [9:0] s0, s1, s2;
    for (int k = k0; k <= k1; k++) begin
      sym_of(p, k, s0, s1, s2);
      add(s0, s1, s2, done && (k == 31), 1'b0, isl);
    end
    if (done && k1 == 31) eq.push_back(p);
  endtask

  task automatic check_pkt(input pkt_t p);
    logic [4:0] e;
    e[4] = (p.hp != ecc_of({40'h0, p.h}, 24));
    for (int i = 0; i < 4; i++) e[i] = (p.p[i] != ecc_of({8'h0, p.d[i]}, 56));
    chk("header",     bus.header,     p.h);
    chk("header_ecc", bus.header_ecc, p.hp);
    chk("sub0",       bus.sub0,       {p.p[0], p.d[0]});
    chk("sub1",       bus.sub1,       {p.p[1], p.d[1]});
    chk("sub2",       bus.sub2,       {p.p[2], p.d[2]});
    chk("sub3",       bus.sub3,       {p.p[3], p.d[3]});
    chk("ecc_error",  bus.ecc_error,  e);
  endtask

  task automatic play();
    step_t s;
    while (sq.size() != 0) begin
      s = sq.pop_front();
      bus.tmds0 = s.s0;
      bus.tmds1 = s.s1;
      bus.tmds2 = s.s2;
      @(posedge clk_pixel);
      #1;
      chk("packet_valid", bus.packet_valid, s.pv);
      chk("sym_error",    bus.sym_error,    s.se);
      chk("in_island",    bus.in_island,    s.isl);
      if (s.pv && eq.size() != 0) check_pkt(eq.pop_front());
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_pv"},  bus.packet_valid, 0);
    chk({tag, "_hdr"}, bus.header, 0);
    chk({tag, "_hp"},  bus.header_ecc, 0);
    chk({tag, "_s0"},  bus.sub0, 0);
    chk({tag, "_s1"},  bus.sub1, 0);
    chk({tag, "_s2"},  bus.sub2, 0);
    chk({tag, "_s3"},  bus.sub3, 0);
    chk({tag, "_ecc"}, bus.ecc_error, 0);
    chk({tag, "_se"},  bus.sym_error, 0);
    chk({tag, "_isl"}, bus.in_island, 0);
    chk({tag, "_hs"},  bus.hsync, 0);
    chk({tag, "_vs"},  bus.vsync, 0);
  endtask

  initial begin
    pkt_t p, acr;
    logic [9:0] s0, s1, s2;

    bus.tmds0 = IDLE_SYM;
    bus.tmds1 = IDLE_SYM;
    bus.tmds2 = IDLE_SYM;
    repeat (3) @(posedge clk_pixel);
    #1;
    check_all_zero("reset");
    reset_n = 1'b1;
    add(IDLE_SYM, IDLE_SYM, IDLE_SYM, 0, 0, 0);
    play();

    // Null packet, trail guard bands carry vsync=1, hsync=0.
    p = '{default: '0};
    add_gb(2'b00, 0, 1); add_gb(2'b00, 0, 1);
    push_pkt(p, 0, 31, 1, 1);
    add_gb(2'b10, 0, 1); add_gb(2'b10, 0, 1);
    add(IDLE_SYM, IDLE_SYM, IDLE_SYM, 0, 0, 0);
    play();
    chk("null_hsync", bus.hsync, 1'b0);
    chk("null_vsync", bus.vsync, 1'b1);

    // Audio clock regeneration: N=6144, CTS=25200 in every subpacket.
    acr = '{default: '0};
    acr.h = 24'h000001;
    for (int i = 0; i < 4; i++) acr.d[i] = 56'h00180070620000;
    acr = fix_parity(acr);
    add_gb(2'b00, 0, 1); add_gb(2'b00, 0, 1);
    push_pkt(acr, 0, 31, 1, 1);
    add_gb(2'b00, 0, 1); add_gb(2'b00, 0, 1);
    add(IDLE_SYM, IDLE_SYM, IDLE_SYM, 0, 0, 0);
    play();
    chk("acr_ecc_clean", bus.ecc_error, 5'b00000);
    acr.p[2][4] = ~acr.p[2][4];
    add_gb(2'b00, 0, 1); add_gb(2'b00, 0, 1);
    push_pkt(acr, 0, 31, 1, 1);
    add_gb(2'b00, 0, 1); add_gb(2'b00, 0, 1);
    add(IDLE_SYM, IDLE_SYM, IDLE_SYM, 0, 0, 0);
    add(IDLE_SYM, IDLE_SYM, IDLE_SYM, 0, 0, 0);
    play();
    chk("acr_ecc_flip", bus.ecc_error, 5'b00100);

    // Back-to-back: three random packets in one island.
    add_gb(2'b01, 0, 1); add_gb(2'b01, 0, 1);
    for (int n = 0; n < 3; n++) push_pkt(rand_pkt(), 0, 31, 1, 1);
    add_gb(2'b01, 0, 1); add_gb(2'b01, 0, 1);
    add(IDLE_SYM, IDLE_SYM, IDLE_SYM, 0, 0, 0);
    play();
    chk("b2b_hsync", bus.hsync, 1'b1);
    chk("b2b_vsync", bus.vsync, 1'b0);

    // Invalid symbol on ch1 at k=10, then a good island.
    p = rand_pkt();
    add_gb(2'b00, 0, 1); add_gb(2'b00, 0, 1);
    push_pkt(p, 0, 9, 0, 1);
    sym_of(p, 10, s0, s1, s2);
    add(s0, VIDEO_SYM, s2, 0, 1, 1);
    add(IDLE_SYM, IDLE_SYM, IDLE_SYM, 0, 0, 0);
    add_gb(2'b00, 0, 1); add_gb(2'b00, 0, 1);
    push_pkt(rand_pkt(), 0, 31, 1, 1);
    add_gb(2'b00, 0, 1); add_gb(2'b00, 0, 1);
    add(IDLE_SYM, IDLE_SYM, IDLE_SYM, 0, 0, 0);
    play();

    // Single lead guard band followed by a TERC4 symbol.
    add_gb(2'b00, 0, 1);
    add(terc4[$urandom_range(0, 15)], terc4[$urandom_range(0, 15)], terc4[$urandom_range(0, 15)], 0, 0, 1);
    add(IDLE_SYM, IDLE_SYM, IDLE_SYM, 0, 0, 0);
    // Guard band at k=5.
    add_gb(2'b00, 0, 1); add_gb(2'b00, 0, 1);
    push_pkt(rand_pkt(), 0, 4, 0, 1);
    add_gb(2'b00, 1, 1);
    add(IDLE_SYM, IDLE_SYM, IDLE_SYM, 0, 0, 0);
    // Third guard band with no packet yet.
    add_gb(2'b00, 0, 1); add_gb(2'b00, 0, 1); add_gb(2'b00, 1, 1);
    add(IDLE_SYM, IDLE_SYM, IDLE_SYM, 0, 0, 0);
    // Only one trail guard band: the packet still counts, the island is malformed.
    add_gb(2'b00, 0, 1); add_gb(2'b00, 0, 1);
    push_pkt(rand_pkt(), 0, 31, 1, 1);
    add_gb(2'b00, 0, 1);
    add(terc4[3], terc4[5], terc4[9], 0, 1, 1);
    add(IDLE_SYM, IDLE_SYM, IDLE_SYM, 0, 0, 0);
    play();

    // MAX_PACKETS complete, one more start is an error.
    add_gb(2'b00, 0, 1); add_gb(2'b00, 0, 1);
    for (int n = 0; n < 18; n++) push_pkt(rand_pkt(), 0, 31, 1, 1);
    sym_of(rand_pkt(), 0, s0, s1, s2);
    add(s0, s1, s2, 0, 1, 1);
    add(IDLE_SYM, IDLE_SYM, IDLE_SYM, 0, 0, 0);
    play();

    // Reset mid-packet at k=20.
    p = rand_pkt();
    add_gb(2'b00, 0, 1); add_gb(2'b00, 0, 1);
    push_pkt(p, 0, 19, 0, 1);
    play();
    sym_of(p, 20, s0, s1, s2);
    bus.tmds0 = s0; bus.tmds1 = s1; bus.tmds2 = s2;
    #2 reset_n = 1'b0;
    #1 check_all_zero("midrst");
    #1 reset_n = 1'b1;
    push_pkt(p, 20, 31, 0, 0);
    add_gb(2'b00, 0, 1);
    add(IDLE_SYM, IDLE_SYM, IDLE_SYM, 0, 0, 1);
    add(IDLE_SYM, IDLE_SYM, IDLE_SYM, 0, 0, 0);
    play();
    chk("midrst_hdr_hold", bus.header, 24'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/hdmi_data_island_receiver.md
# hdmi_data_island_receiver

Sink-side counterpart of the HDMI data-island transmit path. It consumes word-aligned 10-bit TMDS symbols on all three channels, one per `clk_pixel` cycle, and detects data-island guard bands. It TERC4-decodes the island body and reassembles each 32-cycle packet into a header and four subpackets, checking every BCH parity byte. Downstream infoframe/audio parsers use it, and our benches use it in place of ad-hoc decoding.

## Interface
- `MAX_PACKETS`, 18: maximum packets per island; one more raises `sym_error`.
- `clk_pixel` in 1: pixel clock, the only clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `tmds0`, `tmds1`, `tmds2` in 10 each: aligned TMDS symbols, channels 0..2, sampled every rising edge.
- `packet_valid` out 1: one-cycle strobe; the packet outputs are valid while it is high.
- `header` out 24: HB0..HB2, with HB0 in [7:0].
- `header_ecc` out 8: received header parity byte (PB of header).
- `sub0`, `sub1`, `sub2`, `sub3` out 64 each: subpackets; [55:0] = data, [63:56] = received parity.
- `ecc_error` out 5: bit 4 = header, bits 3:0 = subpackets 3..0. 1 = received parity ≠ computed parity. Valid with `packet_valid`.
- `sym_error` out 1: one-cycle pulse on a malformed island.
- `in_island` out 1: high from the first lead guard-band symbol through the last trail guard-band symbol.
- `hsync`, `vsync` out 1 each: TERC4 ch0 bits [0] and [1], updated on every ch0 TERC4 symbol inside an island.

## Operation
- **Guard band (GB):**
  - `tmds1` == `tmds2` == 10'b0100110011.
  - `tmds0` is the TERC4 code of 4'b11xx: 1010001110, 1001110001, 0101100011 or 1011000011.
- **TERC4 decode:** fixed 16-entry table, 0000→1010011100 through 1111→1011000011. Any other code is "invalid".
- **Bit mapping at packet cycle k (0..31):**
  - header bit k = ch0 d[2].
  - sub_i bit 2k = ch1 d[i].
  - sub_i bit 2k+1 = ch2 d[i].
  - Header bits 31:24 are the header parity byte.
- **ECC:**
  - Computed serially over data bits, LSB first, with register `e` cleared at k=0: f = bit ^ e[0]; e = {1'b0, e[7:1]} ^ (f ? 8'h83 : 8'h00).
  - Header: bits 0..23. Subpackets: bits 0..55.
  - Compared against the received parity byte.
  - No correction.
- **FSM:**
  - IDLE: GB → LEAD1.
  - LEAD1: GB → PACKET (k=0, pcount=0); else → IDLE.
  - PACKET:
    - All three channels TERC4-valid → accumulate, k++.
    - At k=31: latch outputs, pcount++, k=0.
    - At k=0 with pcount ≥ 1, GB → TRAIL1.
  - PACKET errors (→ IDLE, pulse `sym_error`):
    - any invalid symbol;
    - a GB at k ≠ 0;
    - a GB at pcount=0;
    - pcount reaching `MAX_PACKETS` and another packet starting.
  - TRAIL1: GB → IDLE (island closed cleanly); else `sym_error`, → IDLE.
  - An aborted partial packet never produces `packet_valid`.

## Timing
- **Reset values:** all outputs 0, including `header`, `sub*` and `ecc_error`. FSM = IDLE; k, pcount and ECC registers = 0. Reset is asynchronous and may occur mid-packet; the partial packet is discarded.
- **Packet latency:** the edge that samples symbol k=31 registers `packet_valid` = 1. It falls on the next edge unless another packet completes.
- **Output hold:** `header`/`sub*`/`ecc_error` hold their last values until the next completion.
- **Back-to-back packets:** k=0 of packet n+1 directly follows k=31 of packet n, so `packet_valid` pulses exactly 32 cycles apart.
- **`sym_error`:** registered on the edge that samples the offending symbol; high for 1 cycle.
- **`in_island`:** rises on the edge sampling the first GB and falls on the edge after the final trail GB or an abort.
- **Island span:** minimum 2 + 32 + 2 = 36 cycles for one packet.

## Test plan
- **Null packet:** 2 GB, 32 symbols encoding an all-zero packet with zero parity, 2 GB. Expect `packet_valid` once, at the edge sampling symbol 31 (cycle 34 from island start); header=0, sub*=0, `ecc_error`=0, `sym_error` never.
- **Parity checked:** audio clock regen packet with HB0=8'h01, N=6144, CTS=25200 in all four subpackets, correct parity. Expect matching `header`/`sub*` and `ecc_error`=5'b00000. Flip received parity bit 60 of sub2 and expect `ecc_error`=5'b00100.
- **Back-to-back:** 3 packets in one island. Expect 3 `packet_valid` pulses 32 cycles apart and `in_island` high for 100 cycles.
- **Invalid symbol:** TMDS video code on ch1 at k=10. Expect `sym_error` pulse, FSM back to IDLE, no `packet_valid`; a following good island decodes normally.
- **Bad guard bands:** a single lead GB followed by a TERC4 symbol gives no island and no `packet_valid`. A GB at k=5 gives `sym_error`.
- **Reset mid-packet:** assert `reset_n`=0 at k=20. Expect all outputs 0 immediately, and no `packet_valid` from the remainder of the island.
